// File: rtl/operand_skew_feeder_if.sv
// operand_skew_feeder_if: operand load port plus the skewed edge streams and run handshake
// of operand_skew_feeder.
interface operand_skew_feeder_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic                 ld_en;
    logic                 ld_sel;
    logic [$clog2(N)-1:0] ld_row;
    logic [$clog2(N)-1:0] ld_col;
    logic [W-1:0]         ld_data;
    logic                 start;
    logic [N*W-1:0]       a_out;
    logic [N*W-1:0]       b_out;
    logic                 acc_clr;
    logic                 stream_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output ld_en, ld_sel, ld_row, ld_col, ld_data, start,
        input  a_out, b_out, acc_clr, stream_valid, busy, done
    );

    modport slave (
        input  ld_en, ld_sel, ld_row, ld_col, ld_data, start,
        output a_out, b_out, acc_clr, stream_valid, busy, done
    );
endinterface

// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: holds N x N A/B operand matrices and streams them, diagonally skewed,
// into the left/top edges of a systolic MAC array with accumulator clear and done handshake.
module operand_skew_feeder #(
    parameter int N     = 3,
    parameter int W     = 8,
    parameter int HOLD  = 1,
    parameter int FLUSH = 2 * N
) (
    input logic                  clk,
    input logic                  rst,
    operand_skew_feeder_if.slave bus
);
    localparam int LAST = 3 * N - 3;
    localparam int BW   = $clog2(3 * N);
    localparam int CW   = $clog2(HOLD + FLUSH + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FLUSHING} state_t;

    state_t         state, state_nxt;
    logic [BW-1:0]  beat, beat_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           done_nxt;
    logic           wr;
    logic [N*W-1:0] a_nxt, b_nxt;
    logic [W-1:0]   a_mem [N][N];
    logic [W-1:0]   b_mem [N][N];

    assign wr = state == IDLE && bus.ld_en && int'(bus.ld_row) < N && int'(bus.ld_col) < N;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
        end else if (wr) begin
            if (bus.ld_sel)
                b_mem[bus.ld_row][bus.ld_col] <= bus.ld_data;
            else
                a_mem[bus.ld_row][bus.ld_col] <= bus.ld_data;
        end

    // cnt paces beats while streaming and counts zero-drive clocks while flushing
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE:   state_nxt = bus.start ? CLEAR : IDLE;
            CLEAR:  state_nxt = STREAM;
            STREAM: begin
                cnt_nxt = cnt == CW'(HOLD - 1) ? '0 : cnt + CW'(1);
                if (cnt == CW'(HOLD - 1)) begin
                    state_nxt = beat == BW'(LAST) ? FLUSHING : STREAM;
                    beat_nxt  = beat == BW'(LAST) ? beat : beat + BW'(1);
                end
            end
            FLUSHING: begin
                cnt_nxt = cnt == CW'(FLUSH - 1) ? '0 : cnt + CW'(1);
                if (cnt == CW'(FLUSH - 1)) begin
                    done_nxt  = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = bus.start ? CLEAR : IDLE;
                end
            end
        endcase
    end

    // row i takes A[i][c] and column c takes B[i][c] on beat i+c
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int i = 0; i < N; i++)
            for (int c = 0; c < N; c++)
                if (state_nxt == STREAM && int'(beat_nxt) == i + c) begin
                    a_nxt[i*W +: W] = a_mem[i][c];
                    b_nxt[c*W +: W] = b_mem[i][c];
                end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state            <= IDLE;
            beat             <= '0;
            cnt              <= '0;
            bus.a_out        <= '0;
            bus.b_out        <= '0;
            bus.acc_clr      <= 1'b0;
            bus.stream_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            state            <= state_nxt;
            beat             <= beat_nxt;
            cnt              <= cnt_nxt;
            bus.a_out        <= a_nxt;
            bus.b_out        <= b_nxt;
            bus.acc_clr      <= state_nxt == CLEAR;
            bus.stream_valid <= state_nxt == STREAM;
            bus.busy         <= state_nxt != IDLE;
            bus.done         <= done_nxt;
        end
endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Synthesizable operand source for the N×N systolic array of `mac_unit` PEs. It holds one N×N A matrix and one N×N B matrix, loaded word by word. On `start` it clears the PE accumulators and streams A rows into the left array edge and B columns into the top edge, with the diagonal skew the array needs. Each beat can be held for several clocks to match PE pacing. It then flushes zeros and signals `done`.

## Interface
- `N`, 3: array dimension (rows of A = columns of B = N).
- `W`, 8: operand width; the 1/3/4 minifloat (sign/exponent bias 3/mantissa); 8'h00 = 0.0.
- `HOLD`, 1: clocks each beat is held on the outputs (≥1).
- `FLUSH`, 2*N: zero-drive clocks after the last beat, so operands propagate through the PE pass-through chain.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_en`  in  1  write one operand word this cycle.
- `ld_sel`  in  1  0 = write A, 1 = write B.
- `ld_row`  in  $clog2(N)  row index.
- `ld_col`  in  $clog2(N)  column index.
- `ld_data`  in  W  operand word.
- `start`  in  1  single-cycle request to begin a run.
- `a_out`  out  N*W  row i drives `[i*W +: W]`, feeding PE(i,0) `a`.
- `b_out`  out  N*W  column j drives `[j*W +: W]`, feeding PE(0,j) `b`.
- `acc_clr`  out  1  one-cycle accumulator clear to all PEs.
- `stream_valid`  out  1  high while beats (not flush zeros) are driven.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.

## Operation
- Storage: 2·N·N registers of width W, all cleared to 0 by `rst`.
- Loads are accepted only in IDLE. Loads while `busy` are dropped, and storage is unchanged.
- Out-of-range indices (≥N, when N is not a power of two) are dropped.
- FSM has four states:
  - IDLE: wait for `start`.
  - CLEAR: 1 clock.
  - STREAM: (3N−2)·HOLD clocks.
  - FLUSH: FLUSH clocks, then back to IDLE.
- Transitions:
  - IDLE→CLEAR on `start`.
  - CLEAR→STREAM unconditionally.
  - STREAM→FLUSH after the last clock of beat 3N−3.
  - FLUSH→IDLE after FLUSH clocks, pulsing `done`.
- Beat b (0…3N−3), row i: `a_out` row i = A[i][b−i] if 0 ≤ b−i < N, else 0.
- Beat b, column j: `b_out` column j = B[b−j][j] if 0 ≤ b−j < N, else 0.
- Beat counter: 0…3N−3. Hold counter: 0…HOLD−1; the beat advances when the hold counter wraps.
- `start` while `busy` is ignored; no queuing.
- `start` and `ld_en` in the same IDLE cycle: the write commits and the run streams the new value.
- Storage is not modified by a run, so back-to-back runs replay the same matrices.

## Timing
- All outputs are registered.
- Reset values: `a_out` = 0, `b_out` = 0, `acc_clr` = 0, `stream_valid` = 0, `busy` = 0, `done` = 0. State = IDLE, counters = 0.
- Let `start` be sampled at edge k.
  - Edge k: `busy`=1 and `acc_clr`=1 for clocks k..k+1. `a_out`/`b_out` stay 0.
  - Edge k+1+b·HOLD: beat b appears and holds HOLD clocks. `stream_valid`=1 from edge k+1 to edge k+1+(3N−2)·HOLD.
  - Edge k+1+(3N−2)·HOLD: outputs go 0 and `stream_valid`=0.
  - Edge T = k+1+(3N−2)·HOLD+FLUSH: `done`=1 for one clock and `busy`=0. A `start` sampled at T begins a new run.
- Total run, N=3, HOLD=1, FLUSH=6: 1+7+6 = 14 clocks.
- `rst` asserted mid-run: outputs and counters go 0 immediately. Storage is cleared, no `done` is issued, and the FSM returns to IDLE.

## Test plan
- Reset: assert `rst` mid-STREAM. All outputs are 0 asynchronously, before the next edge. After release, `busy`=0 and re-run streams all-zero beats.
- Skew, N=3, HOLD=1:
  - Load A row0 = {20,10,30}h and B col0 = {34,44,44}h.
  - Beat 0: `a_out` row0 = 20h, rows 1–2 = 0; `b_out` col0 = 34h.
  - Beat 2: row0 = 30h, row2 = A[2][0].
  - Beat 4: only row2/col2 are nonzero.
  - `stream_valid` is high for exactly 7 clocks.
- Handshake: `acc_clr` is exactly 1 clock, at edge k. `done` pulses at edge k+14, and `busy` falls at the same edge.
- HOLD=5 (the bench's 10-half-period pacing): each beat is stable 5 clocks; `done` arrives at k+1+35+FLUSH.
- Loads during `busy` (e.g. A[0][0]=7Fh) are ignored: the next run still streams 20h. A `start` mid-run does not extend the run.
- Same-cycle `ld_en` (A[1][1]=44h) + `start`: beat 2 row1 = 44h. A back-to-back `start` at the `done` edge begins the next run with no idle gap.
